// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmitter.
//   - Default line settings (CLK_FREQ/BAUD), so a future uart_rx picks up the same values.
//   - One-hot bit indices and the one-hot state type used by uart_tx.
//   - Parity helper function.
package uart_tx_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115_200;

  // One-hot bit index of each FSM state
  localparam int IDLE_IDX   = 0;
  localparam int START_IDX  = 1;
  localparam int DATA_IDX   = 2;
  localparam int PARITY_IDX = 3;
  localparam int STOP_IDX   = 4;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'(1 << IDLE_IDX),
    ST_START  = 5'(1 << START_IDX),
    ST_DATA   = 5'(1 << DATA_IDX),
    ST_PARITY = 5'(1 << PARITY_IDX),
    ST_STOP   = 5'(1 << STOP_IDX)
  } state_t;

  // Parity bit for a byte: even parity is the XOR of the data bits, odd parity its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the upstream read-out stage and uart_tx.
//   tx_data        byte to send (producer -> transmitter)
//   tx_data_valid  producer holds high until it sees tx_data_ack
//   tx_data_ack    one-cycle accept pulse (transmitter -> producer)
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ack;

  modport master (output tx_data, output tx_data_valid, input tx_data_ack);
  modport slave  (input tx_data, input tx_data_valid, output tx_data_ack);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-time counter for the UART transmitter.
//   clk      system clock
//   rst      synchronous active-high reset
//   clr      restarts the bit time (asserted on byte accept)
//   bit_end  high during the last clock of each bit time (count == CLKS_PER_BIT-1)
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  // Width guard keeps elaboration sane until uart_tx rejects CLKS_PER_BIT < 2.
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Counter wraps at LAST; clr aligns a fresh bit time with the accept edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Combinational so the FSM changes bit on exactly the CLKS_PER_BIT-th edge.
  assign bit_end = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter (8 data bits, optional parity, 1 or 2 stop bits).
//   clk    system clock, all logic on posedge
//   rst    synchronous active-high reset; aborts any frame in flight
//   bus    uart_tx_if slave: tx_data / tx_data_valid in, tx_data_ack out (registered pulse)
//   txd    serial line, idle high, registered
//   busy   high from the accept edge until the frame returns to IDLE
module uart_tx import uart_tx_pkg::*; #(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       txd,
  output logic       busy
);

  generate
    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
      $fatal(1, "uart_tx: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
    end
  endgenerate

  state_t     state_r, state_nxt;
  logic       txd_r, txd_nxt;
  logic       ack_r, ack_nxt;
  logic       busy_r, busy_nxt;
  logic [7:0] shift_r, shift_nxt;
  logic [2:0] idx_r, idx_nxt;
  logic       stop_r, stop_nxt;
  logic       par_r, par_nxt;
  logic       clr_s;
  logic       bit_end_s;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .bit_end (bit_end_s)
  );

  // State and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      txd_r   <= 1'b1;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      shift_r <= 8'h00;
      idx_r   <= 3'd0;
      stop_r  <= 1'b0;
      par_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      txd_r   <= txd_nxt;
      ack_r   <= ack_nxt;
      busy_r  <= busy_nxt;
      shift_r <= shift_nxt;
      idx_r   <= idx_nxt;
      stop_r  <= stop_nxt;
      par_r   <= par_nxt;
    end
  end

  // Next-state and next-output logic; the line value is prepared one edge ahead so txd is a flop.
  always_comb begin
    state_nxt = state_r;
    txd_nxt   = txd_r;
    ack_nxt   = 1'b0;
    busy_nxt  = busy_r;
    shift_nxt = shift_r;
    idx_nxt   = idx_r;
    stop_nxt  = stop_r;
    par_nxt   = par_r;
    clr_s     = 1'b0;

    unique case (state_r)
      ST_IDLE: begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (bus.tx_data_valid) begin
          state_nxt = ST_START;
          txd_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          ack_nxt   = 1'b1;
          shift_nxt = bus.tx_data;
          // Parity is taken from the byte as accepted, before shifting destroys it.
          par_nxt   = parity_bit(bus.tx_data, PARITY_ODD != 0);
          clr_s     = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nxt = ST_DATA;
          txd_nxt   = shift_r[0];
          shift_nxt = {1'b0, shift_r[7:1]};
          idx_nxt   = 3'd0;
        end else begin
          state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (idx_r == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_nxt = ST_PARITY;
              txd_nxt   = par_r;
            end else begin
              state_nxt = ST_STOP;
              txd_nxt   = 1'b1;
              stop_nxt  = 1'b0;
            end
          end else begin
            txd_nxt   = shift_r[0];
            shift_nxt = {1'b0, shift_r[7:1]};
            idx_nxt   = idx_r + 3'd1;
          end
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_nxt = ST_STOP;
          txd_nxt   = 1'b1;
          stop_nxt  = 1'b0;
        end else begin
          state_nxt = ST_PARITY;
        end
      end
      ST_STOP: begin
        txd_nxt = 1'b1;
        if (bit_end_s) begin
          // A second stop bit is only sent when configured; stop_r marks that it is in progress.
          if (STOP_BITS == 2 && stop_r == 1'b0) begin
            stop_nxt = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            stop_nxt  = 1'b0;
          end
        end else begin
          state_nxt = ST_STOP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.tx_data_ack = ack_r;
  assign txd             = txd_r;
  assign busy            = busy_r;

endmodule
